compressed_capture: RTL and testbench

Sink for the deflate compressor's output stream. It captures each valid `compressed_data` byte into an internal buffer and counts the bytes. When the compressor asserts `ap_done`, it checks the captured count against the reported `compressed_size`. A random-access read port lets the host or readback logic fetch the captured stream afterwards. It sits beside the compressor in the top level, on the side opposite the image source memory.

---
 rtl/compressed_capture.sv | 173 +++++++++++++++++
 tb/tb_compressed_capture.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/compressed_capture.sv
// Capture sink for the deflate compressor output stream: buffers each strobed
// byte, counts them, and on completion checks the count against the reported size.
module compressed_capture #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_vld,
    input  logic [31:0]   in_size,
    input  logic          in_size_vld,
    input  logic          in_done,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [31:0]   byte_count,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic          size_mismatch
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CHECK   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic          clear_s;
    logic          cnt_en_s;
    logic          size_ld_s;
    logic          check_s;
    logic          wr_en_s;

    logic [AW-1:0] wr_ptr_r;
    logic [31:0]   byte_count_r;
    logic [31:0]   size_latched_r;
    logic          size_seen_r;
    logic          overflow_r;
    logic          size_mismatch_r;
    logic          busy_r;
    logic          done_r;
    logic [7:0]    rd_data_r;
    logic [7:0]    mem [DEPTH];

    // Next-state and per-cycle datapath enables
    always_comb begin
        state_nxt_s = state_r;
        clear_s     = 1'b0;
        cnt_en_s    = 1'b0;
        size_ld_s   = 1'b0;
        check_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = CAPTURE;
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CAPTURE: begin
                // A restart discards whatever else arrives in the same cycle
                if (start) begin
                    state_nxt_s = CAPTURE;
                    clear_s     = 1'b1;
                end else begin
                    cnt_en_s  = in_vld;
                    size_ld_s = in_size_vld;
                    if (in_done) begin
                        state_nxt_s = CHECK;
                    end else begin
                        state_nxt_s = CAPTURE;
                    end
                end
            end
            CHECK: begin
                check_s     = 1'b1;
                state_nxt_s = DONE;
            end
            DONE: begin
                if (start) begin
                    state_nxt_s = CAPTURE;
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign wr_en_s = cnt_en_s && (byte_count_r < 32'(DEPTH));

    // State register with status flags registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == CAPTURE) || (state_nxt_s == CHECK);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Run counters, size latch and result flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r        <= {AW{1'b0}};
            byte_count_r    <= 32'd0;
            size_latched_r  <= 32'd0;
            size_seen_r     <= 1'b0;
            overflow_r      <= 1'b0;
            size_mismatch_r <= 1'b0;
        end else if (clear_s) begin
            wr_ptr_r        <= {AW{1'b0}};
            byte_count_r    <= 32'd0;
            size_latched_r  <= 32'd0;
            size_seen_r     <= 1'b0;
            overflow_r      <= 1'b0;
            size_mismatch_r <= 1'b0;
        end else begin
            if (cnt_en_s) begin
                byte_count_r <= byte_count_r + 32'd1;
                if (wr_en_s) begin
                    wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
                end else begin
                    overflow_r <= 1'b1;
                end
            end
            if (size_ld_s) begin
                size_latched_r <= in_size;
                size_seen_r    <= 1'b1;
            end
            if (check_s) begin
                size_mismatch_r <= !size_seen_r || (size_latched_r != byte_count_r);
            end
        end
    end

    // Capture buffer write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_ptr_r] <= in_data;
        end
    end

    // Read-first synchronous read port, holds when not enabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_r <= 8'd0;
        end else if (rd_en) begin
            rd_data_r <= mem[rd_addr];
        end
    end

    assign rd_data       = rd_data_r;
    assign byte_count    = byte_count_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign overflow      = overflow_r;
    assign size_mismatch = size_mismatch_r;

endmodule

// File: tb/tb_compressed_capture.sv
// Scoreboard bench for compressed_capture: drivers push expected read data and
// run results into queues; a monitor pops and compares when the DUT presents them.
module tb_compressed_capture;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_vld = 1'b0;
    logic [31:0]   in_size = 32'd0;
    logic          in_size_vld = 1'b0;
    logic          in_done = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic [31:0]   byte_count;
    logic          busy;
    logic          done;
    logic          overflow;
    logic          size_mismatch;

    compressed_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_vld(in_vld),
        .in_size(in_size), .in_size_vld(in_size_vld), .in_done(in_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .byte_count(byte_count), .busy(busy), .done(done),
        .overflow(overflow), .size_mismatch(size_mismatch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cnt;
        logic        ovf;
        logic        mism;
        int          cyc;
    } done_exp_t;

    done_exp_t   done_q[$];
    logic [7:0]  rd_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        rd_pend = 1'b0;
    logic        done_prev = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_pend <= rd_en && rst;
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: pops expectations whenever read data or a run result appears
    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
                chk("rd_data", {24'd0, rd_data}, {24'd0, rd_q.pop_front()});
            end
        end
        if (done && !done_prev) begin
            if (done_q.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                done_exp_t e;
                e = done_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("byte_count", byte_count, e.cnt);
                chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                chk("size_mismatch", {31'd0, size_mismatch}, {31'd0, e.mism});
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
        done_prev = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_vld  = 1'b1;
        in_data = b;
        tick();
        in_vld  = 1'b0;
    endtask

    task automatic send_size(input logic [31:0] s);
        in_size_vld = 1'b1;
        in_size     = s;
        tick();
        in_size_vld = 1'b0;
    endtask

    task automatic finish_run(input logic [31:0] cnt, input logic ovf, input logic mism);
        done_exp_t e;
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        e.cnt = cnt; e.ovf = ovf; e.mism = mism; e.cyc = cyc + 1;
        done_q.push_back(e);
        repeat (3) tick();
    endtask

    task automatic read_exp(input logic [AW-1:0] a, input logic [7:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        rd_q.push_back(exp);
        tick();
        rd_en = 1'b0;
    endtask

    logic [7:0] norm_bytes [5] = '{8'h78, 8'h9C, 8'h01, 8'h02, 8'h03};

    initial begin
        #2;
        chk("rst_byte_count", byte_count, 32'd0);
        chk("rst_flags", {27'd0, busy, done, overflow, size_mismatch, 1'b0}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
        rst = 1'b1;
        tick();

        // Normal capture
        do_start();
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) send_byte(norm_bytes[i]);
        send_size(32'd5);
        finish_run(32'd5, 1'b0, 1'b0);
        chk("done_holds", {31'd0, done}, 32'd1);
        for (int i = 0; i < 5; i++) read_exp(AW'(i), norm_bytes[i]);

        // Size differs, then size never reported
        do_start();
        for (int i = 0; i < 4; i++) send_byte(8'(i + 8'h40));
        send_size(32'd6);
        finish_run(32'd4, 1'b0, 1'b1);
        do_start();
        for (int i = 0; i < 4; i++) send_byte(8'(i + 8'h50));
        finish_run(32'd4, 1'b0, 1'b1);

        // Overflow beyond a 16-byte buffer
        do_start();
        for (int i = 0; i < 20; i++) send_byte(8'(i));
        send_size(32'd20);
        finish_run(32'd20, 1'b1, 1'b0);
        read_exp(4'd15, 8'd15);
        read_exp(4'd0, 8'd0);

        // Last byte, size strobe and completion in one cycle
        do_start();
        send_byte(8'h11);
        send_byte(8'h22);
        in_vld = 1'b1; in_data = 8'hAA;
        in_size_vld = 1'b1; in_size = 32'd3;
        begin
            done_exp_t e;
            in_done = 1'b1;
            tick();
            in_done = 1'b0; in_vld = 1'b0; in_size_vld = 1'b0;
            e.cnt = 32'd3; e.ovf = 1'b0; e.mism = 1'b0; e.cyc = cyc + 1;
            done_q.push_back(e);
        end
        repeat (3) tick();
        read_exp(4'd2, 8'hAA);

        // Restart during capture discards the coincident byte
        do_start();
        send_byte(8'h01);
        send_byte(8'h02);
        start = 1'b1; in_vld = 1'b1; in_data = 8'h03;
        tick();
        start = 1'b0; in_vld = 1'b0;
        chk("restart_count", byte_count, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        finish_run(32'd0, 1'b0, 1'b1);

        // Asynchronous reset mid-run
        do_start();
        for (int i = 0; i < 3; i++) send_byte(8'(i + 8'h60));
        #2;
        rst = 1'b0;
        #1;
        chk("arst_byte_count", byte_count, 32'd0);
        chk("arst_flags", {27'd0, busy, done, overflow, size_mismatch, 1'b0}, 32'd0);
        chk("arst_rd_data", {24'd0, rd_data}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        send_byte(8'h77);
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        repeat (4) tick();
        chk("no_done_after_reset", {31'd0, done}, 32'd0);
        chk("idle_count", byte_count, 32'd0);

        chk("done_q_drained", done_q.size(), 32'd0);
        chk("rd_q_drained", rd_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
